fetch_pc_unit: RTL and testbench

- Initiator side of the instruction-memory interface in the IF stage.
- Owns the PC register and issues word-aligned read requests to the instruction memory, which returns data with 1-cycle latency.
- Writes the returned instruction plus its PC and PC+4 into the IF/ID pipeline register.
- Handles hazard stalls (with a one-entry skid buffer), branch redirects from EX, and halt at a program-end address.

---
 rtl/fetch_pc_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_pc_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// IF-stage fetch unit: owns the PC, issues one-cycle-latency instruction reads and
// fills the IF/ID register, with a one-entry skid buffer for stalls, redirects and halt.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] HALT_ADDR = 32'd56,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_rd_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_nextpc,
  output logic        halted,
  output logic        misalign
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pending_q, pending_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_nextpc_q, ifid_nextpc_d;
  logic        misalign_q, misalign_d;

  logic [31:0] target_masked;
  logic        issue;

  assign target_masked = branch_target & ~32'h3;
  assign issue = (state_q == StRun) && !stall && !branch_taken && (pc_q < HALT_ADDR);

  assign imem_rd_en  = issue;
  assign imem_addr   = pc_q;
  assign ifid_valid  = ifid_valid_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_nextpc = ifid_nextpc_q;
  assign halted      = (state_q == StHalt) && !pending_q && !skid_valid_q;
  assign misalign    = misalign_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pending_d     = pending_q;
    req_pc_d      = req_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    ifid_valid_d  = ifid_valid_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_nextpc_d = ifid_nextpc_q;
    misalign_d    = 1'b0;

    if (branch_taken) begin
      // Redirect wins over stall and halt; the in-flight response and skid are dropped.
      pc_d         = target_masked;
      pending_d    = 1'b0;
      skid_valid_d = 1'b0;
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
      misalign_d   = |branch_target[1:0];
      if (state_q != StHalt || target_masked < HALT_ADDR) begin
        state_d = StRun;
      end
    end else begin
      if (state_q == StIdle) begin
        state_d = StRun;
      end else if (state_q == StRun && !(pc_q < HALT_ADDR)) begin
        state_d = StHalt;
      end

      if (stall) begin
        if (pending_q) begin
          skid_valid_d = 1'b1;
          skid_instr_d = imem_rdata;
          skid_pc_d    = req_pc_q;
          pending_d    = 1'b0;
        end
      end else begin
        if (skid_valid_q) begin
          ifid_valid_d  = 1'b1;
          ifid_instr_d  = skid_instr_q;
          ifid_pc_d     = skid_pc_q;
          ifid_nextpc_d = skid_pc_q + 32'd4;
          skid_valid_d  = 1'b0;
        end else if (pending_q) begin
          ifid_valid_d  = 1'b1;
          ifid_instr_d  = imem_rdata;
          ifid_pc_d     = req_pc_q;
          ifid_nextpc_d = req_pc_q + 32'd4;
        end else begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
        end
        pending_d = issue;
        if (issue) begin
          pc_d     = pc_q + 32'd4;
          req_pc_d = pc_q;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      pending_q     <= 1'b0;
      req_pc_q      <= 32'd0;
      skid_valid_q  <= 1'b0;
      skid_instr_q  <= NOP_INSTR;
      skid_pc_q     <= 32'd0;
      ifid_valid_q  <= 1'b0;
      ifid_instr_q  <= NOP_INSTR;
      ifid_pc_q     <= 32'd0;
      ifid_nextpc_q <= 32'd0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pending_q     <= pending_d;
      req_pc_q      <= req_pc_d;
      skid_valid_q  <= skid_valid_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      ifid_valid_q  <= ifid_valid_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_nextpc_q <= ifid_nextpc_d;
      misalign_q    <= misalign_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios with literal expectations, then random
// stall/redirect/reset traffic checked every cycle against a queue-based fetch model.
module tb_fetch_pc_unit;

  localparam logic [31:0] HALT = 32'd56;
  localparam logic [31:0] NOP  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        imem_rd_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic        ifid_valid;
  logic [31:0] ifid_instr, ifid_pc, ifid_nextpc;
  logic        halted, misalign;

  int checks = 0;
  int errors = 0;

  fetch_pc_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_rd_en   (imem_rd_en),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .ifid_valid   (ifid_valid),
    .ifid_instr   (ifid_instr),
    .ifid_pc      (ifid_pc),
    .ifid_nextpc  (ifid_nextpc),
    .halted       (halted),
    .misalign     (misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hA000_0000 + (a >> 2);
  endfunction

  // Instruction memory: word i holds A0000000+i, one-cycle read latency.
  always @(posedge clk) if (imem_rd_en) imem_rdata <= word_at(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: PCs of outstanding requests and of the skid entry as queues.
  logic        m_started, m_halt, m_ifv, m_mis;
  logic [31:0] m_pc, m_ifpc;
  logic [31:0] m_fly[$];
  logic [31:0] m_skid[$];

  function automatic logic exp_issue();
    return m_started && !m_halt && !stall && !branch_taken && (m_pc < HALT);
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_started = 0; m_halt = 0; m_ifv = 0; m_mis = 0; m_pc = 0; m_ifpc = 0;
      m_fly.delete(); m_skid.delete();
    end else begin
      logic [31:0] old_pc;
      logic        iss;
      old_pc = m_pc;
      iss = exp_issue();
      if (branch_taken) begin
        m_pc = branch_target & ~32'h3;
        m_fly.delete(); m_skid.delete();
        m_ifv = 0;
        m_mis = (branch_target[1:0] != 2'b00);
        if (m_halt) m_halt = (m_pc >= HALT);
      end else begin
        m_mis = 0;
        if (stall) begin
          if (m_fly.size() > 0) m_skid.push_back(m_fly.pop_front());
        end else begin
          if (m_skid.size() > 0) begin
            m_ifpc = m_skid.pop_front(); m_ifv = 1;
          end else if (m_fly.size() > 0) begin
            m_ifpc = m_fly.pop_front(); m_ifv = 1;
          end else begin
            m_ifv = 0;
          end
          if (iss) begin
            m_fly.push_back(m_pc);
            m_pc = m_pc + 32'd4;
          end
        end
        if (m_started && !m_halt && old_pc >= HALT) m_halt = 1;
      end
      m_started = 1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("cyc_rd_en", {31'd0, imem_rd_en}, {31'd0, exp_issue()});
      chk("cyc_addr", imem_addr, m_pc);
      chk("cyc_valid", {31'd0, ifid_valid}, {31'd0, m_ifv});
      chk("cyc_instr", ifid_instr, m_ifv ? word_at(m_ifpc) : NOP);
      if (m_ifv) begin
        chk("cyc_pc", ifid_pc, m_ifpc);
        chk("cyc_nextpc", ifid_nextpc, m_ifpc + 32'd4);
      end
      chk("cyc_halted", {31'd0, halted},
          {31'd0, m_halt && m_fly.size() == 0 && m_skid.size() == 0});
      chk("cyc_misalign", {31'd0, misalign}, {31'd0, m_mis});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    tick(2);
    chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_instr", ifid_instr, NOP);
    chk("rst_pc", ifid_pc, 32'd0);
    chk("rst_nextpc", ifid_nextpc, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_rd_en", {31'd0, imem_rd_en}, 32'd0);
    reset = 1'b0;

    // Startup and back-to-back fetch
    tick(1);
    chk("first_rd_en", {31'd0, imem_rd_en}, 32'd1);
    chk("first_addr", imem_addr, 32'd0);
    tick(2);
    chk("if0_instr", ifid_instr, 32'hA000_0000);
    chk("if0_pc", ifid_pc, 32'd0);
    chk("if0_nextpc", ifid_nextpc, 32'd4);
    tick(1);
    chk("if1_instr", ifid_instr, 32'hA000_0001);
    chk("if1_nextpc", ifid_nextpc, 32'd8);

    // Stall for 3 cycles right after addr 8 was issued
    stall = 1'b1;
    tick(3);
    chk("stall_hold_pc", ifid_pc, 32'd4);
    chk("stall_hold_valid", {31'd0, ifid_valid}, 32'd1);
    stall = 1'b0;
    tick(1);
    chk("skid_pc", ifid_pc, 32'd8);
    chk("skid_instr", ifid_instr, 32'hA000_0002);

    // Redirect to 0x20 while addr 12 is pending
    branch_taken = 1'b1; branch_target = 32'h20;
    tick(1);
    branch_taken = 1'b0;
    chk("redir_bubble", {31'd0, ifid_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'h20);
    tick(2);
    chk("redir_ifid_pc", ifid_pc, 32'h20);

    // Misaligned redirect concurrent with stall
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h13;
    tick(1);
    stall = 1'b0; branch_taken = 1'b0;
    chk("mis_pulse", {31'd0, misalign}, 32'd1);
    chk("mis_addr", imem_addr, 32'h10);
    tick(1);
    chk("mis_clear", {31'd0, misalign}, 32'd0);

    // Run to the halt address
    n = 0;
    while (!halted && n < 100) begin
      tick(1);
      n++;
    end
    chk("halt_reached", {31'd0, halted}, 32'd1);
    chk("halt_last_pc", ifid_pc, 32'd52);
    chk("halt_last_valid", {31'd0, ifid_valid}, 32'd1);
    tick(2);
    chk("halt_rd_en", {31'd0, imem_rd_en}, 32'd0);
    chk("halt_drained", {31'd0, ifid_valid}, 32'd0);
    branch_taken = 1'b1; branch_target = 32'd8;
    tick(1);
    branch_taken = 1'b0;
    #1;
    chk("resume_halted", {31'd0, halted}, 32'd0);
    chk("resume_rd_en", {31'd0, imem_rd_en}, 32'd1);
    chk("resume_addr", imem_addr, 32'd8);

    // Reset while stalled with the skid full
    tick(2);
    stall = 1'b1;
    tick(2);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("arst_instr", ifid_instr, NOP);
    chk("arst_pc", ifid_pc, 32'd0);
    chk("arst_rd_en", {31'd0, imem_rd_en}, 32'd0);
    stall = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
    chk("arst_restart_rd_en", {31'd0, imem_rd_en}, 32'd1);
    chk("arst_restart_addr", imem_addr, 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (reset) reset = 1'b0;
      else reset = ($urandom_range(0, 199) == 0);
      stall = ($urandom_range(0, 99) < 30);
      branch_taken = ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 9) == 0) branch_target = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      else branch_target = $urandom_range(0, 90);
      tick(1);
    end
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    tick(2);
    finish_sim();
  end

endmodule
